// File: rtl/pattern_scan_ctrl.sv
`timescale 1ns/1ps
// pattern_scan_ctrl: scans a serial bit stream for a 4-bit pattern and reports match count and first match position.
// Optional feature: define PATTERN_SCAN_NONOVERLAP_EN to add the nonoverlap input (non-overlapping match mode).
module pattern_scan_ctrl (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] pattern,
  input  logic [7:0] length,
`ifdef PATTERN_SCAN_NONOVERLAP_EN
  input  logic       nonoverlap,
`endif
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       bit_ready,
  output logic       busy,
  output logic       done,
  output logic       match_pulse,
  output logic [7:0] match_count,
  output logic [7:0] first_pos
);

  typedef enum logic [1:0] {IDLE, FILL, SCAN, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] pattern_q, pattern_d;
  logic [3:0] hist_q, hist_d;
  logic [7:0] length_q, length_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] count_q, count_d;
  logic [7:0] first_q, first_d;
  logic [2:0] fill_q, fill_d;
  logic       pulse_q, pulse_d;
  logic       nonov_q;
  logic       accept;
  logic       is_match;

`ifdef PATTERN_SCAN_NONOVERLAP_EN
  logic nonov_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      nonov_q <= 1'b0;
    end else begin
      nonov_q <= nonov_d;
    end
  end
`else
  assign nonov_q = 1'b0;
`endif

  assign bit_ready   = (state_q == FILL) || (state_q == SCAN);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign match_pulse = pulse_q;
  assign match_count = count_q;
  assign first_pos   = first_q;
  assign accept      = bit_valid && bit_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pattern_q <= 4'd0;
      length_q  <= 8'd0;
      hist_q    <= 4'd0;
      idx_q     <= 8'd0;
      fill_q    <= 3'd0;
      count_q   <= 8'd0;
      first_q   <= 8'd0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      length_q  <= length_d;
      hist_q    <= hist_d;
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      first_q   <= first_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    length_d  = length_q;
    hist_d    = hist_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    count_d   = count_q;
    first_d   = first_q;
    pulse_d   = 1'b0;
    is_match  = 1'b0;
`ifdef PATTERN_SCAN_NONOVERLAP_EN
    nonov_d   = nonov_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          pattern_d = pattern;
          length_d  = length;
`ifdef PATTERN_SCAN_NONOVERLAP_EN
          nonov_d   = nonoverlap;
`endif
          hist_d    = 4'd0;
          idx_d     = 8'd0;
          fill_d    = 3'd0;
          count_d   = 8'd0;
          first_d   = 8'd0;
          state_d   = (length == 8'd0) ? DONE : FILL;
        end
      end

      FILL, SCAN: begin
        if (accept) begin
          hist_d   = {hist_q[2:0], bit_in};
          idx_d    = idx_q + 8'd1;
          fill_d   = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
          is_match = (fill_d == 3'd4) && (hist_d == pattern_q);
          if (fill_d == 3'd4) begin
            state_d = SCAN;
          end
          if (is_match) begin
            pulse_d = 1'b1;
            if (count_q != 8'hFF) begin
              count_d = count_q + 8'd1;
            end
            if (first_q == 8'd0) begin
              first_d = idx_d;
            end
            // Non-overlapping mode: the next match must be built from four fresh bits.
            if (nonov_q) begin
              fill_d  = 3'd0;
              state_d = FILL;
            end
          end
          // Reaching the programmed length ends the scan regardless of match state.
          if (idx_d == length_q) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
